// File: rtl/i2s_audio_tx.sv
// I2S stereo transmitter: fractional MCLK generator, SCLK/LRCK derived from MCLK events,
// one-frame holding register with valid/ready intake, and a 2*SLOT_BITS frame shifter.
module i2s_audio_tx #(
  parameter int CLK_HZ        = 74250000,
  parameter int FS_HZ         = 48000,
  parameter int MCLK_RATIO    = 256,
  parameter int SLOT_BITS     = 32,
  parameter int SAMPLE_WIDTH  = 16,
  parameter int UNDERFLOW_REP = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [SAMPLE_WIDTH-1:0] sample_l,
  input  logic [SAMPLE_WIDTH-1:0] sample_r,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic                    mute,
  output logic                    audio_mclk,
  output logic                    audio_sclk,
  output logic                    audio_lrck,
  output logic                    audio_dac,
  output logic                    frame_start,
  output logic [15:0]             underflow_cnt
);

  localparam longint CLK_L      = longint'(CLK_HZ);
  localparam longint INC_L      = 2 * longint'(MCLK_RATIO) * longint'(FS_HZ);
  localparam int     ACC_W      = $clog2(2 * CLK_L) + 1;
  localparam int     DIV        = MCLK_RATIO / (2 * SLOT_BITS);
  localparam int     HALF_DIV   = (DIV >= 2) ? (DIV / 2) : 1;
  localparam int     DCW        = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int     FRAME_BITS = 2 * SLOT_BITS;
  localparam int     PW         = $clog2(FRAME_BITS);

  localparam logic [ACC_W-1:0] INC      = ACC_W'(INC_L);
  localparam logic [ACC_W-1:0] CLK_ACC  = ACC_W'(CLK_L);
  localparam logic [DCW-1:0]   DIV_LAST = DCW'(HALF_DIV - 1);
  localparam logic [PW-1:0]    P_LAST   = PW'(FRAME_BITS - 1);
  localparam logic [PW-1:0]    LR_START = PW'(SLOT_BITS - 1);
  localparam logic [PW-1:0]    LR_END   = PW'(FRAME_BITS - 2);

  if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_bad_div
    $error("i2s_audio_tx: MCLK_RATIO/(2*SLOT_BITS) must be an even number >= 2");
  end
  if (SAMPLE_WIDTH > SLOT_BITS) begin : g_bad_width
    $error("i2s_audio_tx: SAMPLE_WIDTH must not exceed SLOT_BITS");
  end
  if (INC_L >= CLK_L) begin : g_bad_rate
    $error("i2s_audio_tx: 2*MCLK_RATIO*FS_HZ must be below CLK_HZ");
  end

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    mclk_q, mclk_d;
  logic [DCW-1:0]          div_cnt_q, div_cnt_d;
  logic                    sclk_q, sclk_d;
  logic [PW-1:0]           pos_q, pos_d;
  logic                    lrck_q, lrck_d;
  logic                    dac_q, dac_d;
  logic                    frame_start_q, frame_start_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                    hold_full_q, hold_full_d;
  logic [SAMPLE_WIDTH-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
  logic [15:0]             ufl_q, ufl_d;

  logic [ACC_W-1:0]        acc_sum;
  logic                    mclk_tick, mclk_rise, sclk_tick, bit_event, frame_load, transfer;
  logic [FRAME_BITS-1:0]   next_frame;
  logic [SAMPLE_WIDTH-1:0] load_l, load_r;

  always_comb begin
    acc_d         = acc_q;
    mclk_d        = mclk_q;
    div_cnt_d     = div_cnt_q;
    sclk_d        = sclk_q;
    pos_d         = pos_q;
    lrck_d        = lrck_q;
    dac_d         = dac_q;
    frame_start_d = 1'b0;
    shift_d       = shift_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    hold_full_d   = hold_full_q;
    last_l_d      = last_l_q;
    last_r_d      = last_r_q;
    ufl_d         = ufl_q;
    sclk_tick     = 1'b0;
    next_frame    = '0;
    load_l        = '0;
    load_r        = '0;

    // Fractional accumulator: one MCLK toggle each time the sum crosses CLK_HZ.
    acc_sum   = acc_q + INC;
    mclk_tick = (acc_sum >= CLK_ACC);
    acc_d     = mclk_tick ? (acc_sum - CLK_ACC) : acc_sum;
    mclk_d    = mclk_q ^ mclk_tick;
    mclk_rise = mclk_tick & ~mclk_q;

    if (mclk_rise) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        sclk_tick = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + DCW'(1);
      end
    end
    sclk_d     = sclk_q ^ sclk_tick;
    bit_event  = sclk_tick & sclk_q;
    frame_load = bit_event & (pos_q == P_LAST);
    transfer   = sample_valid & ~hold_full_q;

    if (bit_event) begin
      pos_d  = frame_load ? '0 : (pos_q + PW'(1));
      lrck_d = (pos_d >= LR_START) && (pos_d <= LR_END);
    end

    // An empty holding register at load time is an underflow; pick the fill frame.
    if (hold_full_q) begin
      load_l = hold_l_q;
      load_r = hold_r_q;
    end else if (UNDERFLOW_REP != 0) begin
      load_l = last_l_q;
      load_r = last_r_q;
    end
    next_frame[FRAME_BITS-1 -: SAMPLE_WIDTH] = load_l;
    next_frame[SLOT_BITS-1 -: SAMPLE_WIDTH]  = load_r;

    if (frame_load) begin
      frame_start_d = 1'b1;
      shift_d       = {next_frame[FRAME_BITS-2:0], 1'b0};
      dac_d         = ~mute & next_frame[FRAME_BITS-1];
      if (hold_full_q) begin
        hold_full_d = 1'b0;
        last_l_d    = hold_l_q;
        last_r_d    = hold_r_q;
      end else if (ufl_q != 16'hFFFF) begin
        ufl_d = ufl_q + 16'd1;
      end
    end else if (bit_event) begin
      shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
      dac_d   = ~mute & shift_q[FRAME_BITS-1];
    end

    // Transfer only ever happens into an empty register, so it always refills for the next frame.
    if (transfer) begin
      hold_l_d    = sample_l;
      hold_r_d    = sample_r;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q         <= '0;
      mclk_q        <= 1'b0;
      div_cnt_q     <= '0;
      sclk_q        <= 1'b0;
      pos_q         <= '0;
      lrck_q        <= 1'b0;
      dac_q         <= 1'b0;
      frame_start_q <= 1'b0;
      shift_q       <= '0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      hold_full_q   <= 1'b0;
      last_l_q      <= '0;
      last_r_q      <= '0;
      ufl_q         <= '0;
    end else begin
      acc_q         <= acc_d;
      mclk_q        <= mclk_d;
      div_cnt_q     <= div_cnt_d;
      sclk_q        <= sclk_d;
      pos_q         <= pos_d;
      lrck_q        <= lrck_d;
      dac_q         <= dac_d;
      frame_start_q <= frame_start_d;
      shift_q       <= shift_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      hold_full_q   <= hold_full_d;
      last_l_q      <= last_l_d;
      last_r_q      <= last_r_d;
      ufl_q         <= ufl_d;
    end
  end

  assign sample_ready  = ~hold_full_q;
  assign audio_mclk    = mclk_q;
  assign audio_sclk    = sclk_q;
  assign audio_lrck    = lrck_q;
  assign audio_dac     = dac_q;
  assign frame_start   = frame_start_q;
  assign underflow_cnt = ufl_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: instance A uses defaults (zero-fill underflow),
// instance B uses 24-bit samples with repeat-last-frame underflow.
module tb_i2s_audio_tx;

  logic        clk = 1'b0;
  logic        reset_a_n, reset_b_n;
  logic [23:0] sample_l, sample_r;
  logic        sample_valid, mute;
  logic        sel;

  logic        ready_a, mclk_a, sclk_a, lrck_a, dac_a, fs_a;
  logic        ready_b, mclk_b, sclk_b, lrck_b, dac_b, fs_b;
  logic [15:0] ufl_a, ufl_b;

  logic        s_ready, s_mclk, s_sclk, s_lrck, s_dac, s_fs;
  logic [15:0] s_ufl;
  logic        sclk_prev;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  i2s_audio_tx dut_a (
    .clk(clk), .reset_n(reset_a_n),
    .sample_l(sample_l[15:0]), .sample_r(sample_r[15:0]),
    .sample_valid(sample_valid), .sample_ready(ready_a), .mute(mute),
    .audio_mclk(mclk_a), .audio_sclk(sclk_a), .audio_lrck(lrck_a), .audio_dac(dac_a),
    .frame_start(fs_a), .underflow_cnt(ufl_a)
  );

  i2s_audio_tx #(.SAMPLE_WIDTH(24), .UNDERFLOW_REP(1)) dut_b (
    .clk(clk), .reset_n(reset_b_n),
    .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .sample_ready(ready_b), .mute(mute),
    .audio_mclk(mclk_b), .audio_sclk(sclk_b), .audio_lrck(lrck_b), .audio_dac(dac_b),
    .frame_start(fs_b), .underflow_cnt(ufl_b)
  );

  assign s_ready = sel ? ready_b : ready_a;
  assign s_mclk  = sel ? mclk_b  : mclk_a;
  assign s_sclk  = sel ? sclk_b  : sclk_a;
  assign s_lrck  = sel ? lrck_b  : lrck_a;
  assign s_dac   = sel ? dac_b   : dac_a;
  assign s_fs    = sel ? fs_b    : fs_a;
  assign s_ufl   = sel ? ufl_b   : ufl_a;

  // SCLK value just before each edge, so a negedge sample can spot a 1->0 bit event.
  always @(posedge clk) sclk_prev <= s_sclk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic waitBitEvent(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (sclk_prev && !s_sclk) ok = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
    end
    if (ok) begin
      sample_l     = l;
      sample_r     = r;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
    end
  endtask

  // Records one full frame bit-by-bit; mute is raised after position mute_on and dropped after mute_off.
  task automatic captureFrame(input int mute_on, input int mute_off,
                              output logic [63:0] bits, output logic [63:0] lr,
                              output int extra_fs, output bit ok);
    bit got;
    ok       = 1'b0;
    extra_fs = 0;
    bits     = '0;
    lr       = '0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (s_fs) ok = 1'b1;
    end
    if (ok) begin
      bits[63] = s_dac;
      lr[63]   = s_lrck;
      for (int p = 1; p < 64; p++) begin
        if (p - 1 == mute_on)  mute = 1'b1;
        if (p - 1 == mute_off) mute = 1'b0;
        waitBitEvent(got);
        if (!got) ok = 1'b0;
        bits[63-p] = s_dac;
        lr[63-p]   = s_lrck;
        if (s_fs) extra_fs++;
      end
    end
  endtask

  task automatic measureWindow(output int first_rise, output int mclk_rises,
                               output int sclk_rises, output int fs_count);
    logic pm = 1'b0;
    logic ps = 1'b0;
    first_rise = 0;
    mclk_rises = 0;
    sclk_rises = 0;
    fs_count   = 0;
    for (int k = 1; k <= 12375; k++) begin
      @(posedge clk);
      #1;
      if (s_mclk && !pm) begin
        mclk_rises++;
        if (first_rise == 0) first_rise = k;
      end
      if (s_sclk && !ps) sclk_rises++;
      if (s_fs) fs_count++;
      pm = s_mclk;
      ps = s_sclk;
    end
  endtask

  localparam logic [63:0] LR_PATTERN = 64'h0000_0001_FFFF_FFFE;

  initial begin
    logic [63:0] bits, lr;
    logic [15:0] word;
    int          extra, first, mr, sr, fsc;
    int          frames, xfers, idx, pos;
    bit          ok, started, done, ready_prev;

    sel          = 1'b0;
    reset_a_n    = 1'b0;
    reset_b_n    = 1'b0;
    sample_l     = '0;
    sample_r     = '0;
    sample_valid = 1'b0;
    mute         = 1'b0;
    #1;
    checkOutput("reset_outputs", {43'd0, s_mclk, s_sclk, s_lrck, s_dac, s_fs, s_ufl}, 64'd0);
    checkOutput("reset_ready", s_ready, 1);

    // 12375 clk is one exact accumulator period: 4096 MCLK toggles, 8 frames.
    repeat (3) @(negedge clk);
    reset_a_n = 1'b1;
    measureWindow(first, mr, sr, fsc);
    checkOutput("t1_first_mclk_cycle", first, 4);
    checkOutput("t1_mclk_rises", mr, 2048);
    checkOutput("t1_sclk_rises", sr, 512);
    checkOutput("t1_frame_starts", fsc, 8);

    @(negedge clk) reset_a_n = 1'b0;
    @(negedge clk) reset_a_n = 1'b1;
    applyStimulus(24'h00A5A5, 24'h000F0F, ok);
    checkOutput("t2_push_ok", ok, 1);
    captureFrame(-1, -1, bits, lr, extra, ok);
    checkOutput("t2_capture_ok", ok, 1);
    checkOutput("t2_frame_bits", bits, 64'hA5A5_0000_0F0F_0000);
    checkOutput("t2_lrck", lr, LR_PATTERN);
    checkOutput("t2_single_fs", extra, 0);
    checkOutput("t2_underflow", s_ufl, 0);

    captureFrame(-1, -1, bits, lr, extra, ok);
    checkOutput("t3_capture_ok", ok, 1);
    checkOutput("t3_zero_frame", bits, 64'd0);
    checkOutput("t3_underflow", s_ufl, 1);

    // valid held high: data advances to the next word right after each accepted transfer.
    idx          = 0;
    sample_l     = 24'h001000;
    sample_r     = 24'h00EFFF;
    sample_valid = 1'b1;
    ready_prev   = s_ready;
    frames       = 0;
    xfers        = 0;
    pos          = 0;
    started      = 1'b0;
    done         = 1'b0;
    word         = '0;
    for (int c = 0; c < 10000 && !done; c++) begin
      @(negedge clk);
      if (ready_prev) begin
        xfers++;
        idx++;
        sample_l = 24'h001000 + 24'(idx);
        sample_r = ~sample_l & 24'h00FFFF;
      end
      ready_prev = s_ready;
      if (sclk_prev && !s_sclk) begin
        if (s_fs) begin
          started = 1'b1;
          pos     = 0;
          frames++;
        end else begin
          pos++;
        end
        if (started && pos < 16) word[15-pos] = s_dac;
        if (started && pos == 15) begin
          checkOutput($sformatf("t4_left_word%0d", frames), word, 16'h1000 + 16'(frames - 1));
          if (frames == 4) done = 1'b1;
        end
      end
    end
    sample_valid = 1'b0;
    checkOutput("t4_frames", frames, 4);
    checkOutput("t4_transfers", xfers, 5);
    checkOutput("t4_underflow", s_ufl, 1);

    applyStimulus(24'h00FFFF, 24'h00FFFF, ok);
    checkOutput("t5_push_ok", ok, 1);
    captureFrame(4, 8, bits, lr, extra, ok);
    checkOutput("t5_capture_ok", ok, 1);
    checkOutput("t5_muted_bits", bits, 64'hF87F_0000_FFFF_0000);
    checkOutput("t5_lrck", lr, LR_PATTERN);

    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (s_fs) ok = 1'b1;
    end
    for (int p = 0; p < 20 && ok; p++) waitBitEvent(ok);
    checkOutput("t6_reach_p20", ok, 1);
    reset_a_n = 1'b0;
    #1;
    checkOutput("t6_reset_outputs", {43'd0, s_mclk, s_sclk, s_lrck, s_dac, s_fs, s_ufl}, 64'd0);
    checkOutput("t6_reset_ready", s_ready, 1);
    @(negedge clk) reset_a_n = 1'b1;
    measureWindow(first, mr, sr, fsc);
    checkOutput("t6_first_mclk_cycle", first, 4);
    checkOutput("t6_mclk_rises", mr, 2048);
    checkOutput("t6_sclk_rises", sr, 512);
    checkOutput("t6_frame_starts", fsc, 8);

    reset_a_n = 1'b0;
    sel       = 1'b1;
    @(negedge clk) reset_b_n = 1'b1;
    applyStimulus(24'h800001, 24'h123456, ok);
    checkOutput("t7_push_ok", ok, 1);
    captureFrame(-1, -1, bits, lr, extra, ok);
    checkOutput("t7_capture_ok", ok, 1);
    checkOutput("t7_frame_bits", bits, 64'h8000_0100_1234_5600);
    checkOutput("t7_lrck", lr, LR_PATTERN);
    checkOutput("t7_single_fs", extra, 0);
    checkOutput("t7_underflow", s_ufl, 0);
    captureFrame(-1, -1, bits, lr, extra, ok);
    checkOutput("t7_rep_capture_ok", ok, 1);
    checkOutput("t7_repeat_bits", bits, 64'h8000_0100_1234_5600);
    checkOutput("t7_rep_underflow", s_ufl, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
